// File: rtl/ak4619_sequencer.sv
// AK4619 power-up and run-time sequencer: PDN hold/wake, I2C config handshake with
// retry, settle period, and the 256-cycle sample strobe that paces all sample processing.
module ak4619_sequencer #(
    parameter int unsigned PDN_HOLD_CYCLES = 4096,
    parameter int unsigned PDN_WAKE_CYCLES = 1024,
    parameter int unsigned CFG_TIMEOUT     = 1048576,
    parameter int unsigned SETTLE_FRAMES   = 16,
    parameter int unsigned MAX_RETRIES     = 3
) (
    input  logic        clk_256fs,
    input  logic        rst_n,
    input  logic        enable,
    output logic        codec_rst,
    output logic        cfg_start,
    input  logic        cfg_busy,
    input  logic        cfg_done,
    input  logic        cfg_err,
    output logic        strobe,
    output logic        running,
    output logic        fault,
    output logic [1:0]  retry_count,
    output logic [15:0] frame_count
);

    // The cycle counter also counts settle strobes, so it covers SETTLE_FRAMES too.
    localparam int unsigned MAX_HW  = (PDN_HOLD_CYCLES > PDN_WAKE_CYCLES) ? PDN_HOLD_CYCLES : PDN_WAKE_CYCLES;
    localparam int unsigned MAX_HWT = (MAX_HW > CFG_TIMEOUT) ? MAX_HW : CFG_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_HWT > SETTLE_FRAMES) ? MAX_HWT : SETTLE_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(PDN_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST   = CNT_W'(PDN_WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(CFG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES);
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        HOLD, WAKE, CFG_REQ, CFG_WAIT, SETTLE, RUN, FAULT
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       phase, phase_d;
    logic             codec_rst_d, cfg_start_d, strobe_d, running_d, fault_d;
    logic [1:0]       retry_d;
    logic [15:0]      frame_d;
    logic             fail;

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HOLD;
            cnt         <= '0;
            phase       <= '0;
            codec_rst   <= 1'b1;
            cfg_start   <= 1'b0;
            strobe      <= 1'b0;
            running     <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            phase       <= phase_d;
            codec_rst   <= codec_rst_d;
            cfg_start   <= cfg_start_d;
            strobe      <= strobe_d;
            running     <= running_d;
            fault       <= fault_d;
            retry_count <= retry_d;
            frame_count <= frame_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        phase_d     = '0;
        codec_rst_d = codec_rst;
        cfg_start_d = 1'b0;
        strobe_d    = 1'b0;
        running_d   = running;
        fault_d     = fault;
        retry_d     = retry_count;
        frame_d     = frame_count;
        fail        = 1'b0;

        if (!enable) begin
            // Disabling abandons whatever is in progress; frame_count is kept for software.
            state_d     = HOLD;
            cnt_d       = '0;
            codec_rst_d = 1'b1;
            running_d   = 1'b0;
            fault_d     = 1'b0;
            retry_d     = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_d     = WAKE;
                        cnt_d       = '0;
                        codec_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                WAKE: begin
                    if (cnt == WAKE_LAST) begin
                        state_d = CFG_REQ;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                CFG_REQ: begin
                    if (!cfg_busy) begin
                        cfg_start_d = 1'b1;
                        state_d     = CFG_WAIT;
                        cnt_d       = '0;
                    end
                end
                CFG_WAIT: begin
                    // An error beats a simultaneous done; done on the last timeout cycle still counts.
                    if (cfg_err || (!cfg_done && cnt == TMO_LAST)) begin
                        fail = 1'b1;
                    end else if (cfg_done) begin
                        state_d  = SETTLE;
                        cnt_d    = CNT_W'(1);
                        strobe_d = 1'b1;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    phase_d = phase + 8'd1;
                    if (phase == 8'hFF) begin
                        strobe_d = 1'b1;
                        if (cnt == SETTLE_LAST) begin
                            state_d   = RUN;
                            running_d = 1'b1;
                            frame_d   = frame_count + 16'd1;
                        end else begin
                            cnt_d = cnt + CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    phase_d = phase + 8'd1;
                    if (phase == 8'hFF) begin
                        strobe_d = 1'b1;
                        frame_d  = frame_count + 16'd1;
                    end
                end
                FAULT: ;
                default: state_d = HOLD;
            endcase
        end

        if (fail) begin
            codec_rst_d = 1'b1;
            cnt_d       = '0;
            if (retry_count < RETRY_LIMIT) begin
                retry_d = retry_count + 2'd1;
                state_d = HOLD;
            end else begin
                state_d = FAULT;
                fault_d = 1'b1;
            end
        end
    end

endmodule
